sync_fifo_ctrl: RTL and testbench

Pointer and flag controller for the synchronous FIFO.
- Accepts push/pop requests and drives the write enable and write/read addresses of the FIFO storage array.
- Reports occupancy and full/empty/almost flags.
- The storage array is write-on-clock-edge with a combinational read port, so the word at `r_addr` is the head of the FIFO: first-word fall-through.
- Sits directly upstream of the storage array. Together they form the complete FIFO.

---
 rtl/sync_fifo_ctrl.sv | 81 ++++++++
 tb/tb_sync_fifo_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Pointer and flag controller for a first-word-fall-through synchronous FIFO.
// Drives the storage write enable and addresses and reports occupancy, threshold and sticky error flags.
module sync_fifo_ctrl #(
  parameter int DEPTH     = 1024,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          we,
  output logic [AW-1:0] w_addr,
  output logic [AW-1:0] r_addr,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [AW:0] AE_LEVEL = (AW+1)'(AE_MARGIN);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits are equal.
  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        push, pop;

  assign w_addr = wp_q[AW-1:0];
  assign r_addr = rp_q[AW-1:0];
  assign count  = wp_q - rp_q;
  assign empty  = (wp_q == rp_q);
  assign full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // rst_n gates push so the storage never sees a write while reset is held.
  assign push = wr_en && !full && rst_n;
  assign pop  = rd_en && !empty;
  assign we   = push;

  // NOTE: every next-state signal gets a default before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    ovf_d = ovf_q | (wr_en & full);
    unf_d = unf_q | (rd_en & empty);
    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order. Only the pointers are
  // reset; the storage array keeps stale words that the pointers then ignore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl at DEPTH=4 with a behavioural storage
// array attached; directed table, corner sequences and a queue-model random run.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          we;
  logic [AW-1:0] w_addr, r_addr;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  logic [7:0] wdata = 8'h00;
  logic [7:0] mem [DEPTH];

  int n_chk = 0;
  int n_err = 0;

  sync_fifo_ctrl #(.DEPTH(DEPTH), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .we(we), .w_addr(w_addr), .r_addr(r_addr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Storage array: write on the clock edge, combinational read.
  always @(posedge clk) if (we) mem[w_addr] <= wdata;

  typedef struct {
    logic       wr, rd, we;
    logic [2:0] cnt;
    logic [1:0] wa, ra;
    logic       full, empty, af, ae, ovf, unf;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic wr, rd, xwe, input logic [2:0] cnt,
                              input logic [1:0] wa, ra,
                              input logic fl, em, af, ae, ov, un);
    vec_t v;
    v.wr = wr; v.rd = rd; v.we = xwe; v.cnt = cnt; v.wa = wa; v.ra = ra;
    v.full = fl; v.empty = em; v.af = af; v.ae = ae; v.ovf = ov; v.unf = un;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wr, input logic rd);
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] wa0, ra0, two;
    logic [7:0] got [$];
    logic [7:0] q   [$];
    bit ovf_m, unf_m, push_ok, pop_ok;
    int pw, pr, sz;

    tbl[0] = mk(1,0, 1, 3'd1, 2'd1, 2'd0, 0,0,0,1, 0,0);
    tbl[1] = mk(1,0, 1, 3'd2, 2'd2, 2'd0, 0,0,0,0, 0,0);
    tbl[2] = mk(1,0, 1, 3'd3, 2'd3, 2'd0, 0,0,1,0, 0,0);
    tbl[3] = mk(1,0, 1, 3'd4, 2'd0, 2'd0, 1,0,1,0, 0,0);
    tbl[4] = mk(1,0, 0, 3'd4, 2'd0, 2'd0, 1,0,1,0, 1,0);
    tbl[5] = mk(0,1, 0, 3'd3, 2'd0, 2'd1, 0,0,1,0, 1,0);
    tbl[6] = mk(0,1, 0, 3'd2, 2'd0, 2'd2, 0,0,0,0, 1,0);
    tbl[7] = mk(0,1, 0, 3'd1, 2'd0, 2'd3, 0,0,0,1, 1,0);
    tbl[8] = mk(0,1, 0, 3'd0, 2'd0, 2'd0, 0,1,0,1, 1,0);
    tbl[9] = mk(0,1, 0, 3'd0, 2'd0, 2'd0, 0,1,0,1, 1,1);

    // Reset asserted mid-cycle after three pushes, with wr_en still high.
    do_reset();
    repeat (3) begin drive(1, 0); tick(); end
    check("pre_reset_count", 32'(count), 32'd3);
    @(negedge clk);
    wr_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_w_addr", 32'(w_addr), 32'd0);
    check("rst_r_addr", 32'(r_addr), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_ae_af", {30'd0, almost_empty, almost_full}, 32'd2);
    check("rst_sticky", {30'd0, overflow, underflow}, 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;

    // Fill past full, then drain past empty.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].wr, tbl[i].rd);
      check($sformatf("tbl%0d_we", i), 32'(we), 32'(tbl[i].we));
      tick();
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_w_addr", i), 32'(w_addr), 32'(tbl[i].wa));
      check($sformatf("tbl%0d_r_addr", i), 32'(r_addr), 32'(tbl[i].ra));
      check($sformatf("tbl%0d_full_empty", i), {30'd0, full, empty}, {30'd0, tbl[i].full, tbl[i].empty});
      check($sformatf("tbl%0d_af_ae", i), {30'd0, almost_full, almost_empty}, {30'd0, tbl[i].af, tbl[i].ae});
      check($sformatf("tbl%0d_ovf_unf", i), {30'd0, overflow, underflow}, {30'd0, tbl[i].ovf, tbl[i].unf});
    end

    // Simultaneous requests at empty, at full, and in the middle.
    do_reset();
    drive(1, 1);
    check("emp_both_we", 32'(we), 32'd1);
    tick();
    check("emp_both_count", 32'(count), 32'd1);
    check("emp_both_empty", 32'(empty), 32'd0);
    check("emp_both_unf", 32'(underflow), 32'd1);
    check("emp_both_ovf", 32'(overflow), 32'd0);
    repeat (3) begin drive(1, 0); tick(); end
    check("refill_full", 32'(full), 32'd1);
    drive(1, 1);
    check("full_both_we", 32'(we), 32'd0);
    tick();
    check("full_both_count", 32'(count), 32'd3);
    check("full_both_full", 32'(full), 32'd0);
    check("full_both_ovf", 32'(overflow), 32'd1);
    drive(0, 1);
    tick();
    check("mid_start_count", 32'(count), 32'd2);
    wa0 = w_addr;
    ra0 = r_addr;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1);
      tick();
      check($sformatf("mid_both%0d_count", i), 32'(count), 32'd2);
    end
    two = 2'd2;
    check("mid_both_w_adv", 32'(w_addr), 32'(2'(wa0 + two)));
    check("mid_both_r_adv", 32'(r_addr), 32'(2'(ra0 + two)));

    // Data ordering across three wraps with pops lagging pushes by two cycles.
    do_reset();
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      wr_en = (k < 12);
      rd_en = (k >= 2);
      wdata = 8'hA1 + 8'(k);
      #1;
      if (rd_en && !empty) got.push_back(mem[r_addr]);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("wrap_pop_total", 32'(got.size()), 32'd12);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("wrap_data%0d", i), 32'(got[i]), 32'(8'hA1 + 8'(i)));
    check("wrap_sticky", {30'd0, overflow, underflow}, 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);

    // Random traffic against a queue model of the FIFO contents.
    do_reset();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      case ((c / 500) % 3)
        0:       begin pw = 75; pr = 35; end
        1:       begin pw = 30; pr = 75; end
        default: begin pw = 55; pr = 55; end
      endcase
      @(negedge clk);
      wr_en = ($urandom_range(99) < pw);
      rd_en = ($urandom_range(99) < pr);
      wdata = 8'($urandom);
      #1;
      sz      = q.size();
      push_ok = wr_en && (sz < DEPTH);
      pop_ok  = rd_en && (sz > 0);
      check("rnd_we", 32'(we), 32'(push_ok));
      if (pop_ok) check("rnd_head", 32'(mem[r_addr]), 32'(q[0]));
      if (wr_en && sz == DEPTH) ovf_m = 1'b1;
      if (rd_en && sz == 0)     unf_m = 1'b1;
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(wdata);
      tick();
      sz = q.size();
      check("rnd_count", 32'(count), 32'(sz));
      check("rnd_full", 32'(full), 32'(sz == DEPTH));
      check("rnd_empty", 32'(empty), 32'(sz == 0));
      check("rnd_af", 32'(almost_full), 32'(sz >= DEPTH - 1));
      check("rnd_ae", 32'(almost_empty), 32'(sz <= 1));
      check("rnd_sticky", {30'd0, overflow, underflow}, {30'd0, ovf_m, unf_m});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
